// File: rtl/inst_queue_pkg.sv
// Shared types for the instruction queue in front of the accelerator control unit.
// The instruction format is shared with the accelerator top and is not changed here.
package inst_queue_pkg;

    localparam int INST_QUEUE_DEPTH = 4;

    typedef logic [$clog2(INST_QUEUE_DEPTH):0] inst_queue_cnt_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  dst;
        logic [15:0] operand;
    } instruction_t;

endpackage

// File: rtl/inst_queue_mem.sv
// Instruction storage: DEPTH x instruction_t registers, one write port and an asynchronous read port.
// Contents are deliberately left unreset; validity is tracked by the queue's count.
module inst_queue_mem
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = INST_QUEUE_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  instruction_t             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output instruction_t             rdata_o
);

    instruction_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_queue.sv
// Instruction FIFO between the host issue port and the accelerator control unit.
// Optional same-cycle bypass when empty is enabled by defining INST_QUEUE_BYPASS_EN.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH     = INST_QUEUE_DEPTH,
    parameter int AF_MARGIN = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  instruction_t           host_inst_i,
    input  logic                   host_valid_i,
    output logic                   host_ready_o,
    output instruction_t           inst_o,
    output logic                   inst_valid_o,
    input  logic                   inst_ready_i,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   almost_full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_MARGIN);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    instruction_t head;
    logic         push, pop;
    logic         push_eff, pop_eff;
    logic         wr_en;

    assign host_ready_o  = (count_q != DEPTH_C);
    assign level_o       = count_q;
    assign empty_o       = (count_q == '0);
    assign almost_full_o = ((DEPTH_C - count_q) <= AF_C);

    assign push = host_valid_i & host_ready_o;
    assign pop  = inst_valid_o & inst_ready_i;

`ifdef INST_QUEUE_BYPASS_EN
    logic bypass;
    logic bypass_take;

    // An empty queue forwards the host word directly; if consumed it never touches storage.
    assign bypass       = (count_q == '0) & host_valid_i & ~flush_i;
    assign bypass_take  = bypass & inst_ready_i;
    assign inst_valid_o = (count_q != '0) | bypass;
    assign inst_o       = bypass ? host_inst_i : head;
    assign push_eff     = push & ~bypass_take;
    assign pop_eff      = pop & ~bypass_take;
`else
    assign inst_valid_o = (count_q != '0);
    assign inst_o       = head;
    assign push_eff     = push;
    assign pop_eff      = pop;
`endif

    assign wr_en = push_eff & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_eff && !pop_eff) begin
                count_d = count_q + CW'(1);
            end else if (pop_eff && !push_eff) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    inst_queue_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk_i  (clk_i),
        .we_i   (wr_en),
        .waddr_i(wr_ptr_q),
        .wdata_i(host_inst_i),
        .raddr_i(rd_ptr_q),
        .rdata_o(head)
    );

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Instruction FIFO directly upstream of the accelerator top.
- Accepts instructions from the host side through a valid/ready handshake.
- Buffers up to DEPTH entries and presents them in order on the inst_i / inst_valid_i / inst_ready_o handshake consumed by the control unit.
- Decouples host issue rate from control-unit stalls during long fetch/compute/commit sequences.

Parameters:
DEPTH, 4, number of instruction entries; power of two, minimum 2.
AF_MARGIN, 1, almost_full_o asserts when free entries <= AF_MARGIN; range 0..DEPTH-1.

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
rst_i  input  1  asynchronous reset, active-high.
flush_i  input  1  synchronous clear of all queued entries.
host_inst_i  input  $bits(instruction_t)  instruction from host.
host_valid_i  input  1  host_inst_i is valid.
host_ready_o  output  1  queue can accept an instruction this cycle.
inst_o  output  $bits(instruction_t)  head instruction, connects to top inst_i.
inst_valid_o  output  1  head is valid, connects to top inst_valid_i.
inst_ready_i  input  1  consumer accepts head, driven by top inst_ready_o.
level_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
almost_full_o  output  1  (DEPTH - level_o) <= AF_MARGIN.
empty_o  output  1  level_o == 0.

Behaviour:
- State:
  - mem[DEPTH] of instruction_t.
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits; wrap naturally from DEPTH-1 to 0.
  - count, $clog2(DEPTH)+1 bits.
- Reset (async, rst_i=1):
  - wr_ptr=0, rd_ptr=0, count=0, taking effect immediately.
  - Outputs: inst_valid_o=0, empty_o=1, level_o=0, host_ready_o=1, almost_full_o=(DEPTH<=AF_MARGIN).
  - mem contents are not reset.
  - inst_o is don't-care while inst_valid_o=0.
- Push and pop conditions:
  - push = host_valid_i & host_ready_o.
  - pop = inst_valid_o & inst_ready_i.
- Output logic (combinational from registers only):
  - host_ready_o = (count != DEPTH).
  - inst_valid_o = (count != 0).
  - inst_o = mem[rd_ptr].
  - No combinational path from inst_ready_i to host_ready_o, or from host_valid_i to inst_valid_o (except in the optional feature).
- Push: mem[wr_ptr] <= host_inst_i; wr_ptr++.
- Pop: rd_ptr++.
- count updates:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Latency: an instruction pushed in cycle N is visible on inst_o with inst_valid_o=1 in cycle N+1 when the queue was empty.
- Full (count==DEPTH):
  - host_ready_o=0, so no push that cycle, even if a pop occurs.
  - Space frees in the next cycle.
- Empty (count==0): inst_valid_o=0, so no pop is possible.
- Simultaneous push and pop at count=1: the head is popped, the new entry is written, count stays 1, and the new entry is the head in the next cycle.
- flush_i=1 at a clock edge:
  - wr_ptr=rd_ptr=0 and count=0.
  - Any push or pop in that cycle is discarded.
  - Flush has priority.
  - Handshake outputs still reflect the pre-flush state in the flush cycle.
- Handshake obligations:
  - Once inst_valid_o=1, inst_o stays stable until popped, unless flushed or reset.
  - Host holds host_inst_i stable while host_valid_i=1 and host_ready_o=0; the queue does not check this.
- Ordering: strict FIFO; no reordering, no dropping outside flush and reset.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and host_valid_i=1, inst_o=host_inst_i and inst_valid_o=1 in the same cycle.
  - If inst_ready_i=1 as well, the instruction passes through without being written; pointers and count are unchanged.
  - Otherwise it is written normally.
  - This makes a combinational path host_valid_i -> inst_valid_o.
  - Bypass is suppressed during flush_i.
- Undefined: behaviour exactly as above, with a minimum latency of 1 cycle.

Decomposition:
- common_pkg additions:
  - INST_QUEUE_DEPTH constant (default 4), used by the integrating level.
  - inst_queue_cnt_t typedef, logic [$clog2(INST_QUEUE_DEPTH):0].
  - instruction_t is reused unchanged.
- One natural sub-module: inst_queue_mem, holding the DEPTH x instruction_t register array with one write port and one asynchronous read port.
- Pointer, count and handshake logic stay in inst_queue.

Test Plan:
- Reset mid-stream: push 3 instructions, assert rst_i asynchronously between edges -> inst_valid_o=0 and level_o=0 immediately; host_ready_o=1.
- Fill, DEPTH=4, inst_ready_i=0: push I0..I4 back to back -> I0..I3 accepted, level_o=4, host_ready_o=0 from the cycle after the 4th push, I4 held. Then inst_ready_i=1 -> I0..I3 pop in order and I4 is accepted once space frees.
- Streaming: host_valid_i and inst_ready_i both high for 20 cycles with incrementing payloads -> output sequence is identical and gap-free after the first cycle, with level_o=1 steady.
- Wrap-around: 10 alternating push/pop pairs at level 2 -> pointers wrap past 3->0 and order is preserved.
- Flush: level_o=3 plus a simultaneous push and pop with flush_i=1 -> next cycle level_o=0, inst_valid_o=0; the pushed instruction never appears.
- almost_full, AF_MARGIN=1: at level_o=3 -> almost_full_o=1; at level_o=2 -> almost_full_o=0. With INST_QUEUE_BYPASS_EN, from empty with host_valid_i=1 and inst_ready_i=1 -> same-cycle inst_o match and level_o stays 0.
